riscv_cu_wb_slave: RTL



---
 rtl/riscv_cu_wb_pkg.sv | 24 ++
 rtl/cu_capture_fifo.sv | 52 +++++
 rtl/riscv_cu_wb_slave.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/riscv_cu_wb_pkg.sv
// Shared constants for the control-unit Wishbone slave: register map, ID,
// STATUS bit positions and the bus FSM state type.
package riscv_cu_wb_pkg;

  localparam logic [7:0] OFF_INSTR     = 8'h00;
  localparam logic [7:0] OFF_CTRL_LIVE = 8'h04;
  localparam logic [7:0] OFF_FIFO_DATA = 8'h08;
  localparam logic [7:0] OFF_STATUS    = 8'h0C;
  localparam logic [7:0] OFF_ID        = 8'h10;

  localparam logic [31:0] ID_VALUE  = 32'h5243_5530;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam int STAT_EMPTY_BIT = 3;
  localparam int STAT_FULL_BIT  = 4;
  localparam int STAT_OVF_BIT   = 5;
  localparam int STAT_IRQEN_BIT = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } bus_state_e;

endpackage

// File: rtl/cu_capture_fifo.sv
// Small capture FIFO for control-unit words. A push into a full FIFO is
// dropped (o_ovf pulses) unless a pop frees a slot on the same edge.
module cu_capture_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_srst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_din,
  output logic [WIDTH-1:0]         o_dout,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty,
  output logic                     o_ovf
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_pop;
  logic             w_do_push;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign o_ovf     = i_push & o_full & ~w_do_pop;
  assign o_count   = r_count;
  assign o_dout    = r_mem[r_rd_ptr];

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_din;
  end

  // Pointers are log2(DEPTH) bits wide, so they wrap on their own.
  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + (AW+1)'(w_do_push) - (AW+1)'(w_do_pop);
    end
  end

endmodule

// File: rtl/riscv_cu_wb_slave.sv
// Wishbone classic slave bridging the management SoC to the RISC-V control
// unit: instruction injection, live/captured control-word readback and IRQ.
module riscv_cu_wb_slave
  import riscv_cu_wb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter int          CTRL_W     = 16,
  parameter int          CU_LAT     = 1,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  output logic [31:0]       cu_instr_o,
  output logic              cu_valid_o,
  input  logic [CTRL_W-1:0] cu_ctrl_i,
  output logic              irq_o
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  bus_state_e        r_state;
  logic              r_ack, r_valid, r_ovf, r_irq_en, r_irq;
  logic [31:0]       r_dat, r_instr;
  logic              w_hit, w_accept, w_wr_instr, w_wr_status, w_pop, w_push;
  logic              w_ovf_set, w_ovf_clr, w_full, w_empty;
  logic [7:0]        w_off;
  logic [31:0]       w_instr_next, w_rdata, w_status;
  logic [CTRL_W-1:0] w_head;
  logic [CNT_W-1:0]  w_count;

  assign w_off       = wbs_adr_i[7:0];
  assign w_hit       = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign w_accept    = (r_state == ST_IDLE) & wbs_cyc_i & wbs_stb_i & w_hit;
  assign w_wr_instr  = w_accept & wbs_we_i & (w_off == OFF_INSTR);
  assign w_wr_status = w_accept & wbs_we_i & (w_off == OFF_STATUS);
  assign w_pop       = w_accept & ~wbs_we_i & (w_off == OFF_FIFO_DATA) & ~w_empty;
  assign w_ovf_clr   = w_wr_status & wbs_sel_i[0] & wbs_dat_i[STAT_OVF_BIT];

  for (genvar gi = 0; gi < 4; gi++) begin : g_byte
    assign w_instr_next[8*gi +: 8] = wbs_sel_i[gi] ? wbs_dat_i[8*gi +: 8] : r_instr[8*gi +: 8];
  end

  // Valid delay line: the control word is stable CU_LAT cycles after the strobe.
  if (CU_LAT == 0) begin : g_nolat
    assign w_push = r_valid;
  end else begin : g_lat
    logic [CU_LAT-1:0] r_dly;
    always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
        r_dly <= '0;
      end else begin
        r_dly[0] <= r_valid;
        for (int i = 1; i < CU_LAT; i++) r_dly[i] <= r_dly[i-1];
      end
    end
    assign w_push = r_dly[CU_LAT-1];
  end

  cu_capture_fifo #(
    .WIDTH (CTRL_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (wb_clk_i),
    .i_srst  (wb_rst_i),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (cu_ctrl_i),
    .o_dout  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_ovf   (w_ovf_set)
  );

  always_comb begin
    w_status                 = '0;
    w_status[2:0]            = 3'(w_count);
    w_status[STAT_EMPTY_BIT] = w_empty;
    w_status[STAT_FULL_BIT]  = w_full;
    w_status[STAT_OVF_BIT]   = r_ovf;
    w_status[STAT_IRQEN_BIT] = r_irq_en;
  end

  always_comb begin
    w_rdata = '0;
    case (w_off)
      OFF_INSTR:     w_rdata = r_instr;
      OFF_CTRL_LIVE: w_rdata = 32'(cu_ctrl_i);
      OFF_FIFO_DATA: w_rdata = w_empty ? 32'h0 : 32'(w_head);
      OFF_STATUS:    w_rdata = w_status;
      OFF_ID:        w_rdata = ID_VALUE;
      default:       w_rdata = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state  <= ST_IDLE;
      r_ack    <= 1'b0;
      r_dat    <= '0;
      r_instr  <= NOP_INSTR;
      r_valid  <= 1'b0;
      r_ovf    <= 1'b0;
      r_irq_en <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_irq   <= r_irq_en & ~w_empty;
      // A capture overflow on the same edge as a clear keeps the flag set.
      if (w_ovf_set)      r_ovf <= 1'b1;
      else if (w_ovf_clr) r_ovf <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state <= ST_ACK;
            r_ack   <= 1'b1;
            r_dat   <= wbs_we_i ? 32'h0 : w_rdata;
            if (w_wr_instr && (wbs_sel_i != 4'h0)) begin
              r_instr <= w_instr_next;
              r_valid <= 1'b1;
            end
            if (w_wr_status && wbs_sel_i[1]) r_irq_en <= wbs_dat_i[STAT_IRQEN_BIT];
          end
        end
        ST_ACK: begin
          r_state <= ST_IDLE;
          r_ack   <= 1'b0;
          r_dat   <= '0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign wbs_ack_o  = r_ack;
  assign wbs_dat_o  = r_dat;
  assign cu_instr_o = r_instr;
  assign cu_valid_o = r_valid;
  assign irq_o      = r_irq;

endmodule
